// File: rtl/mem_sched.sv
// mem_sched: owns the 22-bit external memory port and shares it between the
// boot loader, the CPU memory mapper and periodic refresh, one fixed-length
// access at a time.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | port free, arbitrate loader > saturated refresh > CPU > refresh
// S_ACCESS | one strobe held for ACCESS cycles, address/data frozen
// S_DONE   | strobes low, owner's ack pulses, no arbitration
module mem_sched #(
   parameter int ACCESS = 4,
   parameter int RFMAX  = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ldReq,
   input  logic [21:0] ldA,
   input  logic [7:0]  ldD,
   output logic        ldAck,
   input  logic        cpuReq,
   input  logic        cpuWr,
   input  logic [21:0] cpuA,
   input  logic [7:0]  cpuD,
   output logic [7:0]  cpuQ,
   output logic        cpuAck,
   input  logic        rfStb,
   output logic [21:0] memA,
   output logic [7:0]  memD,
   input  logic [7:0]  memQ,
   output logic        memR,
   output logic        memW,
   output logic        memRf,
   output logic        busy
);

   localparam int RW = $clog2(RFMAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
   typedef enum logic [1:0] {OWN_LD, OWN_CPU, OWN_RF} own_t;

   state_t        r_state;
   own_t          r_own;
   logic [3:0]    r_cnt;
   logic [RW-1:0] r_rf;

   logic w_idle;
   logic w_full;
   logic w_pend;
   logic w_gnt_ld;
   logic w_gnt_rf;
   logic w_gnt_cpu;
   logic w_gnt;

   // IDLE arbitration: loader is absolute, a saturated refresh backlog beats the CPU
   always_comb begin
      w_idle    = (r_state == S_IDLE);
      w_full    = (r_rf == RW'(RFMAX));
      w_pend    = (r_rf != '0);
      w_gnt_ld  = w_idle && ldReq;
      w_gnt_rf  = w_idle && !ldReq && (w_full || (!cpuReq && w_pend));
      w_gnt_cpu = w_idle && !ldReq && !w_full && cpuReq;
      w_gnt     = w_gnt_ld || w_gnt_rf || w_gnt_cpu;
   end

   // Pending-refresh backlog: strobe and grant in the same cycle cancel out
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_rf <= '0;
      end else if (rfStb && !w_gnt_rf) begin
         if (!w_full) r_rf <= r_rf + RW'(1);
      end else if (!rfStb && w_gnt_rf) begin
         r_rf <= r_rf - RW'(1);
      end
   end

   // Access sequencer with registered port drive and ack pulses
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_own   <= OWN_LD;
         r_cnt   <= '0;
         memA    <= '0;
         memD    <= '0;
         memR    <= 1'b0;
         memW    <= 1'b0;
         memRf   <= 1'b0;
         ldAck   <= 1'b0;
         cpuAck  <= 1'b0;
         cpuQ    <= '0;
         busy    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_gnt_ld) begin
                  memA  <= ldA;
                  memD  <= ldD;
                  memW  <= 1'b1;
                  r_own <= OWN_LD;
               end else if (w_gnt_rf) begin
                  memA  <= '0;
                  memD  <= '0;
                  memRf <= 1'b1;
                  r_own <= OWN_RF;
               end else if (w_gnt_cpu) begin
                  memA  <= cpuA;
                  memD  <= cpuD;
                  memW  <= cpuWr;
                  memR  <= !cpuWr;
                  r_own <= OWN_CPU;
               end
               if (w_gnt) begin
                  r_state <= S_ACCESS;
                  r_cnt   <= 4'(ACCESS - 1);
                  busy    <= 1'b1;
               end
            end
            S_ACCESS: begin
               if (r_cnt == '0) begin
                  // memQ is sampled on the final strobe cycle of a CPU read
                  if (r_own == OWN_CPU && memR) cpuQ <= memQ;
                  memR    <= 1'b0;
                  memW    <= 1'b0;
                  memRf   <= 1'b0;
                  ldAck   <= (r_own == OWN_LD);
                  cpuAck  <= (r_own == OWN_CPU);
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_DONE: begin
               ldAck   <= 1'b0;
               cpuAck  <= 1'b0;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_sched.sv
// Scoreboard bench for mem_sched: directed tests push expected port accesses,
// a negedge monitor reconstructs each strobe window and compares it.
module tb_mem_sched;

   localparam int ACCESS = 4;
   localparam int RFMAX  = 3;
   localparam int K_LD = 0, K_CW = 1, K_CR = 2, K_RF = 3, K_BAD = 4;

   logic        clock, reset;
   logic        ldReq;
   logic [21:0] ldA;
   logic [7:0]  ldD;
   logic        ldAck;
   logic        cpuReq, cpuWr;
   logic [21:0] cpuA;
   logic [7:0]  cpuD, cpuQ;
   logic        cpuAck;
   logic        rfStb;
   logic [21:0] memA;
   logic [7:0]  memD, memQ;
   logic        memR, memW, memRf, busy;

   mem_sched #(.ACCESS(ACCESS), .RFMAX(RFMAX)) dut (
      .clock(clock), .reset(reset),
      .ldReq(ldReq), .ldA(ldA), .ldD(ldD), .ldAck(ldAck),
      .cpuReq(cpuReq), .cpuWr(cpuWr), .cpuA(cpuA), .cpuD(cpuD),
      .cpuQ(cpuQ), .cpuAck(cpuAck), .rfStb(rfStb),
      .memA(memA), .memD(memD), .memQ(memQ),
      .memR(memR), .memW(memW), .memRf(memRf), .busy(busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int          kind;
      logic [21:0] a;
      logic [7:0]  d;
      logic [7:0]  q;
   } exp_t;
   exp_t exp_q[$];

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic push(input int k, input logic [21:0] a, input logic [7:0] d,
                       input logic [7:0] q);
      exp_t e;
      e.kind = k; e.a = a; e.d = d; e.q = q;
      exp_q.push_back(e);
   endtask

   // Monitor: one strobe window per access, checked against the queue head
   initial begin
      bit          in_win, ended, unstable, overlap;
      int          wlen, wkind, obs;
      logic [21:0] wa;
      logic [7:0]  wd;
      exp_t        e;
      in_win = 0; unstable = 0; overlap = 0; wlen = 0; wkind = 0; wa = '0; wd = '0;
      forever begin
         @(negedge clock);
         ended = 0;
         if (!reset) begin
            in_win = 0;
         end else begin
            if (memR || memW || memRf) begin
               if (!in_win) begin
                  in_win   = 1;
                  wlen     = 1;
                  wa       = memA;
                  wd       = memD;
                  wkind    = memRf ? 2 : (memW ? 1 : 0);
                  unstable = 0;
                  overlap  = 0;
               end else begin
                  wlen++;
                  if (memA !== wa || memD !== wd) unstable = 1;
                  if (wkind != (memRf ? 2 : (memW ? 1 : 0))) unstable = 1;
               end
               if ($countones({memR, memW, memRf}) != 1) overlap = 1;
            end else if (in_win) begin
               in_win = 0;
               ended  = 1;
            end
            if (ended) begin
               if (wkind == 2)      obs = (ldAck || cpuAck) ? K_BAD : K_RF;
               else if (wkind == 0) obs = (cpuAck && !ldAck) ? K_CR : K_BAD;
               else if (ldAck && !cpuAck) obs = K_LD;
               else if (cpuAck && !ldAck) obs = K_CW;
               else obs = K_BAD;
               if (exp_q.size() == 0) begin
                  chk("unexpected_window_kind", obs, -1);
               end else begin
                  e = exp_q.pop_front();
                  chk("win_kind", obs, e.kind);
                  chk("win_addr", int'(wa), int'(e.a));
                  if (e.kind == K_LD || e.kind == K_CW) chk("win_data", int'(wd), int'(e.d));
                  chk("win_len", wlen, ACCESS);
                  chk("win_stable", int'(unstable), 0);
                  chk("win_onehot", int'(overlap), 0);
                  if (e.kind == K_CR) chk("win_cpuQ", int'(cpuQ), int'(e.q));
               end
            end else if (ldAck || cpuAck) begin
               chk("stray_ack", int'({ldAck, cpuAck}), 0);
            end
         end
      end
   end

   task automatic wait_cpu_ack(output int ack_cyc);
      ack_cyc = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (cpuAck) begin
            ack_cyc = cyc;
            break;
         end
      end
      if (ack_cyc < 0) chk("cpu_ack_timeout", 0, 1);
      @(posedge clock);
      #1 cpuReq = 1'b0;
   endtask

   task automatic cpu_access(input logic wr, input logic [21:0] a, input logic [7:0] d,
                             output int ack_cyc);
      cpuWr = wr; cpuA = a; cpuD = d; cpuReq = 1'b1;
      wait_cpu_ack(ack_cyc);
   endtask

   task automatic ld_access(input logic [21:0] a, input logic [7:0] d, output int ack_cyc);
      ldA = a; ldD = d; ldReq = 1'b1;
      ack_cyc = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (ldAck) begin
            ack_cyc = cyc;
            break;
         end
      end
      if (ack_cyc < 0) chk("ld_ack_timeout", 0, 1);
      @(posedge clock);
      #1 ldReq = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 300) begin
         @(negedge clock);
         n++;
      end
      repeat (ACCESS + 4) @(negedge clock);
      chk("drain_queue_empty", exp_q.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int a1, a2, c0, la, ca;
      ldReq = 0; ldA = '0; ldD = '0;
      cpuReq = 0; cpuWr = 0; cpuA = '0; cpuD = '0;
      rfStb = 0; memQ = '0;
      reset = 1'b1;
      #2 reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_memA", int'(memA), 0);
      chk("rst_memD", int'(memD), 0);
      chk("rst_cpuQ", int'(cpuQ), 0);
      chk("rst_strobes", int'({memR, memW, memRf}), 0);
      chk("rst_acks", int'({ldAck, cpuAck}), 0);
      chk("rst_busy", int'(busy), 0);
      reset = 1'b1;

      // Reset mid-access abandons the write; held request is re-issued afterwards
      @(posedge clock); #1;
      cpuWr = 1'b1; cpuA = 22'h012345; cpuD = 8'hA5; cpuReq = 1'b1;
      @(posedge clock);
      @(posedge clock); #1;
      chk("t1_memW_before_reset", int'(memW), 1);
      reset = 1'b0;
      #1;
      chk("t1_memW_async", int'(memW), 0);
      chk("t1_memA_async", int'(memA), 0);
      chk("t1_busy_async", int'(busy), 0);
      push(K_CW, 22'h012345, 8'hA5, 8'h00);
      @(posedge clock);
      @(posedge clock); #1 reset = 1'b1;
      wait_cpu_ack(a1);
      drain();

      // Single CPU read, requester inputs wiggle after grant
      memQ = 8'h5A;
      push(K_CR, 22'h1C0000, 8'h00, 8'h5A);
      @(posedge clock); #1;
      c0 = cyc;
      fork
         cpu_access(1'b0, 22'h1C0000, 8'h00, a1);
         begin
            repeat (2) @(posedge clock);
            #1 cpuA = 22'h000000; cpuWr = 1'b1; cpuD = 8'hEE;
         end
      join
      chk("t2_latency", a1 - c0, ACCESS + 1);
      drain();
      chk("t2_cpuQ_held", int'(cpuQ), 8'h5A);

      // Loader and CPU together with one refresh pending: loader, CPU, refresh
      push(K_LD, 22'h2AAAAA, 8'h11, 8'h00);
      push(K_CW, 22'h3FFFFF, 8'h3C, 8'h00);
      push(K_RF, 22'h000000, 8'h00, 8'h00);
      @(posedge clock); #1;
      rfStb = 1'b1;
      fork
         ld_access(22'h2AAAAA, 8'h11, a1);
         cpu_access(1'b1, 22'h3FFFFF, 8'h3C, a2);
         begin
            @(posedge clock);
            #1 rfStb = 1'b0;
         end
      join
      chk("t3_cpu_after_ld_spacing", a2 - a1, ACCESS + 2);
      drain();

      // Five strobes during a loader burst saturate at 3; the first refresh
      // preempts the waiting CPU, the remaining two follow the CPU access
      for (int i = 0; i < 5; i++) push(K_LD, 22'(32'h100 + i), 8'(32'h20 + i), 8'h00);
      push(K_RF, 22'h000000, 8'h00, 8'h00);
      push(K_CW, 22'h155555, 8'h77, 8'h00);
      push(K_RF, 22'h000000, 8'h00, 8'h00);
      push(K_RF, 22'h000000, 8'h00, 8'h00);
      @(posedge clock); #1;
      fork
         begin
            for (int i = 0; i < 5; i++) ld_access(22'(32'h100 + i), 8'(32'h20 + i), la);
         end
         begin
            for (int j = 0; j < 5; j++) begin
               @(posedge clock); #1 rfStb = 1'b1;
               @(posedge clock); #1 rfStb = 1'b0;
               @(posedge clock);
            end
         end
         begin
            repeat (3) @(posedge clock);
            #1 cpu_access(1'b1, 22'h155555, 8'h77, ca);
         end
      join
      chk("t4_cpu_after_loader", int'(ca > la), 1);
      drain();

      // Strobe in the same cycle as a refresh grant keeps the count at 1
      push(K_RF, 22'h000000, 8'h00, 8'h00);
      push(K_RF, 22'h000000, 8'h00, 8'h00);
      @(posedge clock); #1 rfStb = 1'b1;
      @(posedge clock); #1;
      @(posedge clock); #1 rfStb = 1'b0;
      drain();

      // Back-to-back CPU: read then write, ack spacing ACCESS+2
      memQ = 8'hC3;
      push(K_CR, 22'h0ABCDE, 8'h00, 8'hC3);
      push(K_CW, 22'h2ABCDE, 8'h96, 8'h00);
      @(posedge clock); #1;
      cpu_access(1'b0, 22'h0ABCDE, 8'h00, a1);
      memQ = 8'hFF;
      cpu_access(1'b1, 22'h2ABCDE, 8'h96, a2);
      chk("t6_ack_spacing", a2 - a1, ACCESS + 2);
      drain();
      chk("t6_cpuQ_kept_over_write", int'(cpuQ), 8'hC3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
